prog_sequencer: RTL and testbench

//  Parametrised program sequencer: generational successor to the fetch-side PC logic. Generates prog_ctr for instr_ROM.

---
 rtl/prog_sequencer_if.sv | 31 +++
 rtl/prog_sequencer.sv | 150 +++++++++++++++
 tb/tb_prog_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/prog_sequencer_if.sv
// Control-side bundle of the program sequencer: start handshake, flow-control
// requests from decode, and the fetch address/status returned to the core.
interface prog_sequencer_if #(
    parameter int D = 12,
    parameter int S = 4
);
    localparam int DW = $clog2(S + 1);

    logic          req;
    logic          stall;
    logic          branch_en;
    logic          jump_en;
    logic          call_en;
    logic          ret_en;
    logic [D-1:0]  target;
    logic [D-1:0]  prog_ctr;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] depth;

    modport master (
        output req, stall, branch_en, jump_en, call_en, ret_en, target,
        input  prog_ctr, busy, done, err, depth
    );

    modport slave (
        input  req, stall, branch_en, jump_en, call_en, ret_en, target,
        output prog_ctr, busy, done, err, depth
    );
endinterface

// File: rtl/prog_sequencer.sv
// Program sequencer: generates prog_ctr for instr_ROM with jump, relative branch,
// call/return stack, stall, req/done handshake and sticky stack-fault flag.
module prog_sequencer #(
    parameter int D        = 12,
    parameter int S        = 4,
    parameter int END_ADDR = 256
) (
    input  logic              clk,
    input  logic              reset,
    prog_sequencer_if.slave   bus
);
    localparam int DW = $clog2(S + 1);
    localparam int AW = (S > 1) ? $clog2(S) : 1;
    localparam logic [D-1:0]  END_PC  = D'(END_ADDR);
    localparam logic [DW-1:0] FULL_DP = DW'(S);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [D-1:0]  r_pc;
    logic [DW-1:0] r_depth;
    logic          r_err;
    logic          r_busy;
    logic          r_done;
    logic [D-1:0]  r_stack [S];

    state_t        w_state_nxt;
    logic [D-1:0]  w_pc_nxt;
    logic [DW-1:0] w_depth_nxt;
    logic          w_err_nxt;
    logic          w_push;
    logic          w_fault;
    logic [D-1:0]  w_pc_inc;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    assign w_pc_inc = r_pc + D'(1);
    assign w_wr_idx = AW'(r_depth);
    assign w_rd_idx = AW'(r_depth - DW'(1));

    // Next-state, next-PC and stack-control decode
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_depth_nxt = r_depth;
        w_err_nxt   = r_err;
        w_push      = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = '0;
                    w_depth_nxt = '0;
                    w_err_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    if (bus.ret_en) begin
                        if (r_depth == DW'(0)) begin
                            w_fault = 1'b1;
                        end else begin
                            w_pc_nxt    = r_stack[w_rd_idx];
                            w_depth_nxt = r_depth - DW'(1);
                        end
                    end else if (bus.call_en) begin
                        if (r_depth == FULL_DP) begin
                            w_fault = 1'b1;
                        end else begin
                            w_push      = 1'b1;
                            w_depth_nxt = r_depth + DW'(1);
                            w_pc_nxt    = bus.target;
                        end
                    end else if (bus.jump_en) begin
                        w_pc_nxt = bus.target;
                    end else if (bus.branch_en) begin
                        // Same-width add is the sign-extended offset taken mod 2**D
                        w_pc_nxt = r_pc + bus.target;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end

                    if (w_fault) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else if (w_pc_nxt == END_PC) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!bus.req) begin
                    w_state_nxt = ST_IDLE;
                    w_pc_nxt    = '0;
                    w_depth_nxt = '0;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_pc_nxt    = '0;
                w_depth_nxt = '0;
            end
        endcase
    end

    // State, PC and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_depth <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_depth <= w_depth_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Return-address storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign bus.prog_ctr = r_pc;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.depth    = r_depth;
endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer (D=12, S=4, END_ADDR=256) with
// hand-computed expectations checked by immediate assertions.
module tb_prog_sequencer;
    localparam int D = 12;
    localparam int S = 4;
    localparam int END_ADDR = 256;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    prog_sequencer_if #(.D(D), .S(S)) bus ();

    prog_sequencer #(.D(D), .S(S), .END_ADDR(END_ADDR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic s, input logic b, input logic j, input logic c,
                       input logic r, input logic [D-1:0] t);
        bus.stall     = s;
        bus.branch_en = b;
        bus.jump_en   = j;
        bus.call_en   = c;
        bus.ret_en    = r;
        bus.target    = t;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.req = 1'b0;
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        #1;
        chk("rst_pc",    32'(bus.prog_ctr), 32'h0);
        chk("rst_busy",  32'(bus.busy),     32'h0);
        chk("rst_done",  32'(bus.done),     32'h0);
        chk("rst_err",   32'(bus.err),      32'h0);
        chk("rst_depth", 32'(bus.depth),    32'h0);
        step();
        step();
        reset = 1'b0;

        // T1: start and sequential fetch
        bus.req = 1'b1;
        step();
        chk("t1_busy", 32'(bus.busy), 32'h1);
        chk("t1_pc0",  32'(bus.prog_ctr), 32'h0);
        bus.req = 1'b0;
        step(); chk("t1_pc1", 32'(bus.prog_ctr), 32'h1);
        step(); chk("t1_pc2", 32'(bus.prog_ctr), 32'h2);
        step(); chk("t1_pc3", 32'(bus.prog_ctr), 32'h3);
        chk("t1_done", 32'(bus.done), 32'h0);
        for (int i = 0; i < 7; i++) step();
        chk("t1_pc10", 32'(bus.prog_ctr), 32'd10);

        // T2: branch back, jump, branch wrapping forward past 0xFFF
        ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hFFD);
        step(); chk("t2_br_back", 32'(bus.prog_ctr), 32'd7);
        ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h040);
        step(); chk("t2_jump", 32'(bus.prog_ctr), 32'h040);
        ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'hFFF);
        step(); chk("t2_jump_top", 32'(bus.prog_ctr), 32'hFFF);
        ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h002);
        step(); chk("t2_br_wrap", 32'(bus.prog_ctr), 32'h001);

        // T3: call/ret, then underflow with call+ret together
        ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h005);
        step(); chk("t3_pc5", 32'(bus.prog_ctr), 32'h005);
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h080);
        step();
        chk("t3_call_pc", 32'(bus.prog_ctr), 32'h080);
        chk("t3_call_dp", 32'(bus.depth), 32'h1);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        step();
        chk("t3_ret_pc", 32'(bus.prog_ctr), 32'h006);
        chk("t3_ret_dp", 32'(bus.depth), 32'h0);
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123);
        step();
        chk("t3_uf_err",  32'(bus.err),      32'h1);
        chk("t3_uf_done", 32'(bus.done),     32'h1);
        chk("t3_uf_busy", 32'(bus.busy),     32'h0);
        chk("t3_uf_pc",   32'(bus.prog_ctr), 32'h006);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        step();
        chk("t3_idle_pc",   32'(bus.prog_ctr), 32'h0);
        chk("t3_idle_done", 32'(bus.done),     32'h0);
        chk("t3_idle_err",  32'(bus.err),      32'h1);
        bus.req = 1'b1;
        step();
        chk("t3_rerun_busy", 32'(bus.busy), 32'h1);
        chk("t3_rerun_err",  32'(bus.err),  32'h0);

        // T4: fill the stack, check LIFO order, then overflow
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h010); step();
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h020); step();
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h030); step();
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h040); step();
        chk("t4_dp4", 32'(bus.depth), 32'h4);
        chk("t4_pc",  32'(bus.prog_ctr), 32'h040);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000); step();
        chk("t4_ret_pc", 32'(bus.prog_ctr), 32'h031);
        chk("t4_ret_dp", 32'(bus.depth), 32'h3);
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h040); step();
        ctl(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h050); step();
        chk("t4_of_err",  32'(bus.err),      32'h1);
        chk("t4_of_done", 32'(bus.done),     32'h1);
        chk("t4_of_pc",   32'(bus.prog_ctr), 32'h040);
        chk("t4_of_dp",   32'(bus.depth),    32'h4);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        bus.req = 1'b0;
        step();
        chk("t4_idle_dp", 32'(bus.depth), 32'h0);

        // T5: termination at END_ADDR and DONE hold with req high
        bus.req = 1'b1;
        step();
        ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0FF); step();
        chk("t5_pc255", 32'(bus.prog_ctr), 32'h0FF);
        chk("t5_done0", 32'(bus.done), 32'h0);
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000); step();
        chk("t5_end_pc",   32'(bus.prog_ctr), 32'h100);
        chk("t5_end_done", 32'(bus.done),     32'h1);
        chk("t5_end_busy", 32'(bus.busy),     32'h0);
        for (int i = 0; i < 3; i++) begin
            ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h055);
            step();
            chk("t5_hold_pc",   32'(bus.prog_ctr), 32'h100);
            chk("t5_hold_done", 32'(bus.done),     32'h1);
        end
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        bus.req = 1'b0;
        step();
        chk("t5_idle_pc",   32'(bus.prog_ctr), 32'h0);
        chk("t5_idle_done", 32'(bus.done),     32'h0);

        // T6: stall freezes a pending jump; async reset aborts the run
        bus.req = 1'b1;
        step();
        ctl(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd20); step();
        chk("t6_pc20", 32'(bus.prog_ctr), 32'd20);
        ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h300);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_stall_pc", 32'(bus.prog_ctr), 32'd20);
        end
        ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        for (int i = 0; i < 10; i++) step();
        chk("t6_pc30", 32'(bus.prog_ctr), 32'd30);
        bus.req = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t6_ar_pc",   32'(bus.prog_ctr), 32'h0);
        chk("t6_ar_busy", 32'(bus.busy),     32'h0);
        #1 reset = 1'b0;
        step();
        chk("t6_after_pc",   32'(bus.prog_ctr), 32'h0);
        chk("t6_after_busy", 32'(bus.busy),     32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
